// File: rtl/layer_1_tile_gather.sv
// Regroups the row-major layer-1 conv stream (4 pixels x 4 channels per beat) into 4x4 tiles.
// Rows 0-2 of each band are parked in a line buffer; the row-3 beat completes and emits a tile.
module layer_1_tile_gather #(
    parameter int unsigned IMG_W = 24,
    parameter int unsigned IMG_H = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data_1,
    input  logic [63:0]  in_data_2,
    input  logic [63:0]  in_data_3,
    input  logic [63:0]  in_data_4,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_data_1,
    output logic [255:0] out_data_2,
    output logic [255:0] out_data_3,
    output logic [255:0] out_data_4,
    output logic         out_last
);
    localparam int unsigned SEGS   = IMG_W / 4;
    localparam int unsigned BANDS  = IMG_H / 4;
    localparam int unsigned SEG_W  = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int unsigned BAND_W = (BANDS > 1) ? $clog2(BANDS) : 1;
    localparam logic [SEG_W-1:0]  SEG_LAST  = SEG_W'(SEGS - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(BANDS - 1);

    logic [SEG_W-1:0]  r_seg;
    logic [1:0]        r_row;
    logic [BAND_W-1:0] r_band;
    logic              r_out_valid;
    logic              r_out_last;
    logic [255:0]      r_out_data [4];
    logic [63:0]       r_buf [4][3][SEGS];

    logic [63:0] w_in [4];
    logic        w_accept;
    logic        w_row3;
    logic        w_seg_wrap;

    assign w_in[0] = in_data_1;
    assign w_in[1] = in_data_2;
    assign w_in[2] = in_data_3;
    assign w_in[3] = in_data_4;

    // Only a row-3 beat needs the output register, so only it can be back-pressured.
    assign in_ready   = (r_row != 2'd3) || !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_row3     = w_accept && (r_row == 2'd3);
    assign w_seg_wrap = (r_seg == SEG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg  <= '0;
            r_row  <= '0;
            r_band <= '0;
        end else if (w_accept) begin
            if (w_seg_wrap) begin
                r_seg <= '0;
                r_row <= r_row + 2'd1;
                if (r_row == 2'd3) begin
                    r_band <= (r_band == BAND_LAST) ? '0 : r_band + 1'b1;
                end
            end else begin
                r_seg <= r_seg + 1'b1;
            end
        end
    end

    // No reset: every entry is rewritten by rows 0-2 before a row-3 beat reads it.
    always_ff @(posedge clk) begin
        if (w_accept && (r_row != 2'd3)) begin
            for (int ch = 0; ch < 4; ch++) begin
                r_buf[ch][r_row][r_seg] <= w_in[ch];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                r_out_data[ch] <= '0;
            end
        end else if (w_row3) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_seg_wrap && (r_band == BAND_LAST);
            for (int ch = 0; ch < 4; ch++) begin
                r_out_data[ch] <= {w_in[ch], r_buf[ch][2][r_seg], r_buf[ch][1][r_seg],
                                   r_buf[ch][0][r_seg]};
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_data_1 = r_out_data[0];
    assign out_data_2 = r_out_data[1];
    assign out_data_3 = r_out_data[2];
    assign out_data_4 = r_out_data[3];
endmodule

// File: tb/tb_layer_1_tile_gather.sv
// Bench for layer_1_tile_gather: 8x8 ramp table plus randomized 24x24 frames against a tile model.
module tb_layer_1_tile_gather;
    localparam int W  = 24;
    localparam int H  = 24;
    localparam int S  = W / 4;
    localparam int NB = S * H;

    typedef struct packed {
        logic [1023:0] d;
        logic          last;
    } tile_t;

    typedef struct {
        int          tile;
        int          ch;
        int          word;
        logic [15:0] pix;
        logic        last;
    } vec8_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [63:0]  in_data_1, in_data_2, in_data_3, in_data_4;
    logic [255:0] out_data_1, out_data_2, out_data_3, out_data_4;

    logic         v8, ir8, ov8, ordy8, ol8;
    logic [63:0]  d8_1, d8_2, d8_3, d8_4;
    logic [255:0] od8_1, od8_2, od8_3, od8_4;

    layer_1_tile_gather #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data_1(in_data_1), .in_data_2(in_data_2), .in_data_3(in_data_3),
        .in_data_4(in_data_4), .out_valid(out_valid), .out_ready(out_ready),
        .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3),
        .out_data_4(out_data_4), .out_last(out_last)
    );

    layer_1_tile_gather #(.IMG_W(8), .IMG_H(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
        .in_data_1(d8_1), .in_data_2(d8_2), .in_data_3(d8_3), .in_data_4(d8_4),
        .out_valid(ov8), .out_ready(ordy8), .out_data_1(od8_1), .out_data_2(od8_2),
        .out_data_3(od8_3), .out_data_4(od8_4), .out_last(ol8)
    );

    int    n_vec = 0;
    int    n_err = 0;
    int    n_stall = 0;
    int    tiles_seen = 0;
    int    vrun = 0;
    int    vrun_max = 0;
    int    n8 = 0;
    logic  rdy_rand = 1'b0;
    tile_t exp_q[$];
    logic [1023:0] cap8 [4];
    logic          cap8_last [4];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // kind 0: ramp y*W+x (+0x100 per channel); kind 1: seeded hash
    function automatic logic [15:0] pix(input int kind, input int unsigned seed,
                                        input int unsigned ch, input int unsigned y,
                                        input int unsigned x);
        int unsigned h;
        if (kind == 0) return 16'(y * 32'(W) + x + ch * 32'd256);
        h = (y * 32'd131 + x * 32'd7 + ch * 32'd1031 + seed) * 32'h9E3779B1;
        return h[31:16];
    endfunction

    function automatic logic [63:0] seg64(input int kind, input int unsigned seed,
                                          input int ch, input int y, input int s);
        logic [63:0] v;
        for (int c = 0; c < 4; c++) v[c*16 +: 16] = pix(kind, seed, ch, y, s * 4 + c);
        return v;
    endfunction

    // Reference: tile (band, tx) word r*4+c is pixel (band*4+r, tx*4+c)
    task automatic push_frame(input int kind, input int unsigned seed);
        tile_t t;
        for (int band = 0; band < H / 4; band++) begin
            for (int tx = 0; tx < S; tx++) begin
                for (int ch = 0; ch < 4; ch++)
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++)
                            t.d[ch*256 + (r*4+c)*16 +: 16] =
                                pix(kind, seed, ch, band * 4 + r, tx * 4 + c);
                t.last = (band == H / 4 - 1) && (tx == S - 1);
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic cycle_ready();
        if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_beat(input int kind, input int unsigned seed, input int b);
        in_valid  = 1'b1;
        in_data_1 = seg64(kind, seed, 0, b / S, b % S);
        in_data_2 = seg64(kind, seed, 1, b / S, b % S);
        in_data_3 = seg64(kind, seed, 2, b / S, b % S);
        in_data_4 = seg64(kind, seed, 3, b / S, b % S);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input int kind, input int unsigned seed, input int b,
                             input int gap, output int waited);
        waited = 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            cycle_ready();
            @(posedge clk); #1;
        end
        drive_beat(kind, seed, b);
        cycle_ready();
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 500) begin
                $display("FAIL in_ready_timeout: beat %0d got stalled %0d cycles, want < 500",
                         b, waited);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
                $fatal(1);
            end
            @(posedge clk); #1;
            cycle_ready();
            @(negedge clk);
        end
        if (waited > 0) n_stall++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_beats(input int kind, input int unsigned seed, input int b0,
                             input int b1, input int gapmax);
        int waited;
        for (int b = b0; b <= b1; b++)
            send_beat(kind, seed, b, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0,
                      waited);
    endtask

    task automatic drain();
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin : mon
        tile_t t;
        if (rst_n && out_valid) vrun++;
        else vrun = 0;
        if (vrun > vrun_max) vrun_max = vrun;
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tile_extra: got unexpected tile d1=%h, want none", out_data_1);
            end else begin
                t = exp_q.pop_front();
                tiles_seen++;
                if ({out_data_4, out_data_3, out_data_2, out_data_1} !== t.d
                    || out_last !== t.last) begin
                    n_err++;
                    $display("FAIL tile %0d: got last=%b d1=%h, want last=%b d1=%h",
                             tiles_seen, out_last, out_data_1, t.last, t.d[255:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov8 && ordy8 && n8 < 4) begin
            cap8[n8]      = {od8_4, od8_3, od8_2, od8_1};
            cap8_last[n8] = ol8;
            n8++;
        end
    end

    initial begin
        vec8_t tab[$];
        int first_tile[16] = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17, 18, 19, 24, 25, 26, 27};
        int waited;
        int unsigned seed;
        logic [1023:0] snap;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data_1 = '0; in_data_2 = '0; in_data_3 = '0; in_data_4 = '0;
        v8 = 1'b0; ordy8 = 1'b1; d8_1 = '0; d8_2 = '0; d8_3 = '0; d8_4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", {out_data_4, out_data_3, out_data_2, out_data_1} == '0, 1);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // 8x8 ramp frame on the small instance, checked from a table
        for (int b = 0; b < 16; b++) begin
            v8 = 1'b1;
            for (int c = 0; c < 4; c++) begin
                d8_1[c*16 +: 16] = 16'((b / 2) * 8 + (b % 2) * 4 + c);
                d8_2[c*16 +: 16] = 16'((b / 2) * 8 + (b % 2) * 4 + c + 'h100);
                d8_3[c*16 +: 16] = 16'((b / 2) * 8 + (b % 2) * 4 + c + 'h200);
                d8_4[c*16 +: 16] = 16'((b / 2) * 8 + (b % 2) * 4 + c + 'h300);
            end
            @(posedge clk); #1;
        end
        v8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) tab.push_back('{0, 0, i, 16'(first_tile[i]), 1'b0});
        tab.push_back('{1, 0, 0, 16'd4, 1'b0});
        tab.push_back('{2, 0, 0, 16'd32, 1'b0});
        tab.push_back('{3, 0, 0, 16'd36, 1'b1});
        tab.push_back('{0, 1, 4, 16'h108, 1'b0});
        tab.push_back('{0, 3, 15, 16'h31B, 1'b0});
        tab.push_back('{3, 3, 5, 16'h32D, 1'b1});
        check("ramp8_tiles", n8, 4);
        foreach (tab[i]) begin
            check("ramp8_pix", cap8[tab[i].tile][tab[i].ch*256 + tab[i].word*16 +: 16],
                  tab[i].pix);
            check("ramp8_last", cap8_last[tab[i].tile], tab[i].last);
        end

        // Idle rows 0-2 with out_ready low, then backpressure on row 3
        push_frame(0, 0);
        tiles_seen = 0;
        for (int b = 0; b < 18; b++) begin
            send_beat(0, 0, b, 0, waited);
            check("idle_in_ready_stall", waited, 0);
        end
        send_beat(0, 0, 18, 0, waited);
        drive_beat(0, 0, 19);
        @(negedge clk);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        snap = {out_data_4, out_data_3, out_data_2, out_data_1};
        repeat (10) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_hold", {out_data_4, out_data_3, out_data_2, out_data_1} === snap, 1);
            check("bp_stall", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_valid", out_valid, 1);
        @(posedge clk); #1;
        rdy_rand = 1'b1;
        run_beats(0, 0, 20, NB - 1, 2);
        drain();
        check("bp_tiles", tiles_seen, 36);

        // Transfer and load every cycle through row 3
        seed = $urandom;
        push_frame(1, seed);
        tiles_seen = 0;
        vrun_max = 0;
        run_beats(1, seed, 0, NB - 1, 0);
        drain();
        check("sim_valid_run", vrun_max, 6);
        check("sim_tiles", tiles_seen, 36);

        // Reset during band 2, row 3, seg 4 with a tile pending
        seed = $urandom;
        push_frame(1, seed);
        run_beats(1, seed, 0, 11 * S + 3, 0);
        check("mid_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", out_valid, 0);
        check("mid_async_data", {out_data_4, out_data_3, out_data_2, out_data_1} == '0, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        seed = $urandom;
        push_frame(1, seed);
        tiles_seen = 0;
        rdy_rand = 1'b1;
        run_beats(1, seed, 0, NB - 1, 2);
        drain();
        check("mid_restart_tiles", tiles_seen, 36);

        // Two ramp frames back to back
        push_frame(0, 0);
        push_frame(0, 0);
        tiles_seen = 0;
        n_stall = 0;
        run_beats(0, 0, 0, NB - 1, 0);
        run_beats(0, 0, 0, NB - 1, 0);
        drain();
        check("b2b_stalls", n_stall, 0);
        check("b2b_tiles", tiles_seen, 72);

        // One more random frame under random backpressure and gaps
        seed = $urandom;
        push_frame(1, seed);
        tiles_seen = 0;
        rdy_rand = 1'b1;
        run_beats(1, seed, 0, NB - 1, 3);
        drain();
        check("rand_tiles", tiles_seen, 36);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
